pipe_ctrl_s: RTL and testbench

Pipeline sequencer for the 5-stage core. It combines the hazard unit's load-use stall, the EX-stage branch redirect and the data-memory ready handshake into per-stage register enables, flushes and bubbles. It also runs a halt/drain state machine and keeps wrap-around performance counters. It sits between the hazard detection unit and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/perf_ctr_s.sv | 26 ++
 rtl/pipe_ctrl_s.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_s.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, drain default
// and the per-stage enable/flush control pair.
package pipe_ctrl_pkg;

  localparam int unsigned DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctl_t;

endpackage

// File: rtl/perf_ctr_s.sv
// Free-running wrap-around event counter.
module perf_ctr_s #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_s.sv
// Pipeline sequencer: merges load-use stall, branch redirect and dmem wait into
// per-stage enables/flushes, runs the halt/drain FSM and the perf counters.
module pipe_ctrl_s
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdu_stall,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_e         state_q, state_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           halted_q, halted_d;

  stage_ctl_t pc_c, ifid_c, idex_c, exmem_c, memwb_c;
  logic       bubble_c;
  logic       freeze_c;
  logic       stall_inc_c, wait_inc_c, flush_inc_c;

  assign freeze_c = dmem_req & ~dmem_ready;

  // Next state, drain counter and per-stage controls in priority order.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_c        = '0;
    ifid_c      = '0;
    idex_c      = '0;
    exmem_c     = '0;
    memwb_c     = '0;
    bubble_c    = 1'b0;
    stall_inc_c = 1'b0;
    wait_inc_c  = 1'b0;
    flush_inc_c = 1'b0;

    if (!rst) begin
      unique case (state_q)
        ST_RUN, ST_MEM_WAIT, ST_DRAIN: begin
          if (freeze_c) begin
            memwb_c.en = 1'b1;
            bubble_c   = 1'b1;
            wait_inc_c = 1'b1;
          end else if (br_taken) begin
            pc_c        = '{en: 1'b1, flush: 1'b0};
            ifid_c      = '{en: 1'b1, flush: 1'b1};
            idex_c      = '{en: 1'b1, flush: 1'b1};
            exmem_c.en  = 1'b1;
            memwb_c.en  = 1'b1;
            flush_inc_c = 1'b1;
          end else if (hdu_stall) begin
            ifid_c.flush = (state_q == ST_DRAIN);
            idex_c       = '{en: 1'b1, flush: 1'b1};
            exmem_c.en   = 1'b1;
            memwb_c.en   = 1'b1;
            stall_inc_c  = 1'b1;
          end else begin
            pc_c.en      = (state_q != ST_DRAIN);
            ifid_c       = '{en: 1'b1, flush: (state_q == ST_DRAIN)};
            idex_c.en    = 1'b1;
            exmem_c.en   = 1'b1;
            memwb_c.en   = 1'b1;
          end

          if (state_q == ST_DRAIN) begin
            // Dropping halt_req aborts the drain; in-flight bubbles are harmless.
            if (!halt_req) begin
              state_d = ST_RUN;
            end else if (!freeze_c) begin
              if (br_taken) begin
                drain_cnt_d = '0;
              end else if (!hdu_stall) begin
                if (drain_cnt_q == DRAIN_LAST) state_d = ST_HALTED;
                else drain_cnt_d = drain_cnt_q + DCW'(1);
              end
            end
          end else if (freeze_c) begin
            state_d = ST_MEM_WAIT;
          end else if (halt_req) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALTED: begin
          if (!halt_req) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign halted_d = (state_d == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign pc_en        = pc_c.en;
  assign ifid_en      = ifid_c.en;
  assign idex_en      = idex_c.en;
  assign exmem_en     = exmem_c.en;
  assign memwb_en     = memwb_c.en;
  assign ifid_flush   = ifid_c.flush;
  assign idex_flush   = idex_c.flush;
  assign memwb_bubble = bubble_c;
  assign halted       = halted_q;
  assign state_o      = state_q;

  perf_ctr_s #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc_c),
    .cnt_o (stall_cnt)
  );

  perf_ctr_s #(.CNT_W(CNT_W)) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wait_inc_c),
    .cnt_o (wait_cnt)
  );

  perf_ctr_s #(.CNT_W(CNT_W)) u_flush_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_inc_c),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_s.sv
// Bench for pipe_ctrl_s: directed steps plus random traffic, compared each cycle
// against a behavioural model of the sequencer rules.
module tb_pipe_ctrl_s;

  localparam int unsigned CW = 4;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hdu_stall = 1'b0, br_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, memwb_bubble, halted;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, wait_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=run, 1=drain, 2=halted; frz_prev marks a frozen run cycle.
  int m_mode = 0;
  int m_dc   = 0;
  bit m_frz_prev = 1'b0;
  int m_stall = 0, m_wait = 0, m_flush = 0;

  pipe_ctrl_s #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .hdu_stall    (hdu_stall),
    .br_taken     (br_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .state_o      (state_o),
    .stall_cnt    (stall_cnt),
    .wait_cnt     (wait_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,bubble}.
  function automatic logic [7:0] exp_ctl(input int mode, input logic hs, input logic br,
                                         input logic dq, input logic dr);
    logic dr_mode;
    dr_mode = (mode == 1);
    if (mode == 2)   return 8'b0000_0000;
    if (dq && !dr)   return 8'b0000_1001;
    if (br)          return 8'b1111_1110;
    if (hs)          return {5'b00111, dr_mode, 2'b10};
    return {!dr_mode, 4'b1111, dr_mode, 2'b00};
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_mode == 2) return 2'd3;
    if (m_mode == 1) return 2'd2;
    return m_frz_prev ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [7:0] obs_ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};
  endfunction

  task automatic model_step(input logic hs, input logic br, input logic dq,
                            input logic dr, input logic hr);
    bit fz;
    fz = dq && !dr;
    if (m_mode != 2) begin
      if (fz)      m_wait  = (m_wait + 1) % 16;
      else if (br) m_flush = (m_flush + 1) % 16;
      else if (hs) m_stall = (m_stall + 1) % 16;
    end
    case (m_mode)
      0: begin
        m_frz_prev = fz;
        if (hr && !fz) begin m_mode = 1; m_dc = 0; end
      end
      1: begin
        m_frz_prev = 1'b0;
        if (!hr) m_mode = 0;
        else if (!fz) begin
          if (br) m_dc = 0;
          else if (!hs) begin
            m_dc++;
            if (m_dc == DC) m_mode = 2;
          end
        end
      end
      default: begin
        m_frz_prev = 1'b0;
        if (!hr) m_mode = 0;
      end
    endcase
  endtask

  // One clock cycle: drive at negedge, check, then advance the model on posedge.
  task automatic cyc(input logic hs, input logic br, input logic dq,
                     input logic dr, input logic hr);
    @(negedge clk);
    hdu_stall = hs; br_taken = br; dmem_req = dq; dmem_ready = dr; halt_req = hr;
    #1;
    chk("ctl",   32'(obs_ctl()), 32'(exp_ctl(m_mode, hs, br, dq, dr)));
    chk("state", 32'(state_o),   32'(exp_state()));
    chk("halted", 32'(halted),   32'(m_mode == 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("wait_cnt",  32'(wait_cnt),  32'(m_wait));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    model_step(hs, br, dq, dr, hr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    hdu_stall = 1'b1; br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_ctl",   32'(obs_ctl()), 32'h0);
    chk("rst_state", 32'(state_o),   32'h0);
    chk("rst_halted", 32'(halted),   32'h0);
    chk("rst_cnts",  32'({stall_cnt, wait_cnt, flush_cnt}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0; m_dc = 0; m_frz_prev = 1'b0; m_stall = 0; m_wait = 0; m_flush = 0;
  endtask

  initial begin
    int edges;
    bit hr;

    do_reset();
    cyc(0, 0, 0, 0, 0);
    // Load-use stall, then branch colliding with a stall.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Three frozen cycles, then the access completes.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0);
    #2;
    chk("wait_after_freeze", 32'(wait_cnt), 32'd3);
    chk("stall_after_seq",   32'(stall_cnt), 32'd1);
    chk("flush_after_seq",   32'(flush_cnt), 32'd1);

    // Minimum halt latency from RUN, then release.
    do_reset();
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 1);
      edges++;
      #2;
      if (halted) break;
    end
    chk("halt_latency", 32'(edges), 32'(1 + DC));
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Freeze inside DRAIN holds the counter; branch restarts it.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Reset in the middle of a drain.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    // 17 load-use stalls wrap the 4-bit counter to 1.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #2;
    chk("stall_wrap", 32'(stall_cnt), 32'd1);

    // Random traffic against the model, with a reset part way through.
    hr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) hr = ~hr;
      if (i == 200) do_reset();
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
          ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, hr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
